// File: rtl/neuron_mac_engine.sv
// neuron_mac_engine: multi-lane streaming MAC neuron with bias, selectable activation and saturation.
module neuron_mac_engine #(
   parameter int N     = 16,
   parameter int FRAC  = 8,
   parameter int P     = 4,
   parameter int ACC_W = 40
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           in_last,
   input  logic [P-1:0]   in_lane_en,
   input  logic [P*N-1:0] x_data,
   input  logic [P*N-1:0] w_data,
   input  logic [N-1:0]   bias,
   input  logic [1:0]     act_mode,
   output logic           res_valid,
   input  logic           res_ready,
   output logic [N-1:0]   res_data,
   output logic           res_sat,
   output logic           busy
);
   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUTPUT} state_t;
   localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};
   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1} << FRAC;
   state_t                  state_q;
   logic                    cnt_q;
   logic signed [2*N-1:0]   prod_q [P];
   logic signed [2*N-1:0]   prod_d [P];
   logic                    p_vld_q, p_first_q;
   logic signed [ACC_W-1:0] acc_q, lane_sum_d, bias_ext_d, s_d;
   logic signed [N-1:0]     bias_q;
   logic [1:0]              mode_q;
   logic [N-1:0]            data_d;
   logic                    sat_d, accept_d, hi_d, lo_d, step_d, neg_d;
   assign in_ready = (state_q == IDLE) || (state_q == ACCUM);
   assign busy     = state_q != IDLE;
   assign accept_d = in_valid && in_ready;
   always_comb begin
      lane_sum_d = '0;
      for (int i = 0; i < P; i++) begin
         prod_d[i] = in_lane_en[i] ? (2*N)'($signed(x_data[i*N +: N])) * (2*N)'($signed(w_data[i*N +: N])) : '0;
         lane_sum_d = lane_sum_d + ACC_W'(prod_q[i]);
      end
   end
   // Products carry 2*FRAC fractional bits, so bias is aligned to that scale before adding.
   assign bias_ext_d = ACC_W'(bias_q) <<< FRAC;
   assign s_d    = acc_q >>> FRAC;
   assign hi_d   = s_d > MAX_V;
   assign lo_d   = s_d < MIN_V;
   assign step_d = mode_q == 2'd2;
   assign neg_d  = (mode_q == 2'd1) && s_d[ACC_W-1];
   assign sat_d  = !step_d && !neg_d && (hi_d || lo_d);
   assign data_d = step_d ? ((!s_d[ACC_W-1] && s_d != '0) ? ONE : '0) :
                   neg_d  ? '0 :
                   hi_d   ? MAX_V[N-1:0] :
                   lo_d   ? MIN_V[N-1:0] : s_d[N-1:0];
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prod_q    <= '{default: '0};
         p_vld_q   <= 1'b0;
         p_first_q <= 1'b0;
         acc_q     <= '0;
         bias_q    <= '0;
         mode_q    <= '0;
      end else begin
         p_vld_q <= accept_d;
         if (accept_d) begin
            prod_q    <= prod_d;
            p_first_q <= state_q == IDLE;
            if (state_q == IDLE) begin
               bias_q <= bias;
               mode_q <= act_mode;
            end
         end
         if (p_vld_q) acc_q <= (p_first_q ? bias_ext_d : acc_q) + lane_sum_d;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_sat   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (accept_d) begin
               state_q <= in_last ? DRAIN : ACCUM;
               cnt_q   <= 1'b0;
            end
            ACCUM: if (accept_d && in_last) begin
               state_q <= DRAIN;
               cnt_q   <= 1'b0;
            end
            DRAIN: if (cnt_q) begin
               state_q   <= OUTPUT;
               res_valid <= 1'b1;
               res_data  <= data_d;
               res_sat   <= sat_d;
            end else begin
               cnt_q <= 1'b1;
            end
            default: if (res_ready) begin
               state_q   <= IDLE;
               res_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_neuron_mac_engine.sv
// tb_neuron_mac_engine: directed checks of the neuron MAC engine (N=16, FRAC=8, P=4; 1.0 = 0x0100).
module tb_neuron_mac_engine;
   logic        clk = 1'b0, rst = 1'b0;
   logic        in_valid = 1'b0, in_last = 1'b0, res_ready = 1'b0;
   logic        in_ready, res_valid, res_sat, busy;
   logic [3:0]  in_lane_en = '0;
   logic [63:0] x_data = '0, w_data = '0;
   logic [15:0] bias = '0, res_data;
   logic [1:0]  act_mode = '0;
   int          vectors = 0, miscompares = 0;
   neuron_mac_engine dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .in_lane_en(in_lane_en), .x_data(x_data), .w_data(w_data), .bias(bias), .act_mode(act_mode),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_sat(res_sat), .busy(busy)
   );
   always #5 clk = ~clk;
   function automatic logic [63:0] ln(input logic [15:0] a, b, c, d);
      return {d, c, b, a};
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // Starts and ends just after a falling edge; the beat is accepted on the rising edge in between.
   task automatic beat(input string tag, input logic [63:0] x, w, input logic [3:0] en,
                       input logic last, input logic [15:0] b, input logic [1:0] m);
      x_data = x; w_data = w; in_lane_en = en; in_last = last; bias = b; act_mode = m;
      in_valid = 1'b1;
      chk({tag, "_in_ready"}, in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      x_data = {4{16'hDEAD}}; w_data = {4{16'hBEEF}}; bias = 16'h5A5A; act_mode = 2'd3;
   endtask
   task automatic result(input string tag, input logic [15:0] exp_d, input logic exp_s);
      for (int i = 0; i < 20 && !res_valid; i++) @(negedge clk);
      chk({tag, "_valid"}, res_valid, 1);
      chk({tag, "_data"}, res_data, exp_d);
      chk({tag, "_sat"}, res_sat, exp_s);
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      chk({tag, "_released"}, res_valid, 0);
   endtask
   initial begin
      logic [63:0] ones, big, nbig, garb;
      ones = ln(16'h0100, 16'h0100, 16'h0100, 16'h0100);
      big  = ln(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00);
      nbig = ln(16'h8100, 16'h8100, 16'h8100, 16'h8100);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_res_data", res_data, 0);
      rst = 1'b1;
      @(negedge clk);
      // 1.0*1.0 + 2.0*2.0 + -1.0*-1.0 + 0.5*0.5 = 6.25
      beat("t1", ln(16'h0100, 16'h0200, 16'hFF00, 16'h0080), ln(16'h0100, 16'h0200, 16'hFF00, 16'h0080),
           4'hF, 1'b1, 16'h0000, 2'd0);
      chk("t1_lat_half", res_valid, 0);
      chk("t1_busy", busy, 1);
      @(negedge clk);
      chk("t1_lat_1", res_valid, 0);
      @(negedge clk);
      chk("t1_lat_2", res_valid, 1);
      chk("t1_in_ready_out", in_ready, 0);
      result("t1", 16'h0640, 1'b0);
      beat("t2a_b0", ones, ones, 4'hF, 1'b0, 16'hFE00, 2'd1);
      repeat (2) @(negedge clk);
      chk("t2a_gap_busy", busy, 1);
      chk("t2a_gap_ready", in_ready, 1);
      beat("t2a_b1", ones, ones, 4'hF, 1'b0, 16'h0000, 2'd0);
      @(negedge clk);
      beat("t2a_b2", ones, ones, 4'hF, 1'b1, 16'h0000, 2'd0);
      result("t2a", 16'h0A00, 1'b0);
      beat("t2b_b0", ones, ones, 4'hF, 1'b0, 16'hEC00, 2'd1);
      @(negedge clk);
      beat("t2b_b1", ones, ones, 4'hF, 1'b0, 16'h0000, 2'd0);
      beat("t2b_b2", ones, ones, 4'hF, 1'b1, 16'h0000, 2'd0);
      result("t2b", 16'h0000, 1'b0);
      beat("t3a_b0", big, big, 4'hF, 1'b0, 16'h0000, 2'd0);
      repeat (2) beat("t3a_bm", big, big, 4'hF, 1'b0, 16'h0000, 2'd1);
      beat("t3a_b3", big, big, 4'hF, 1'b1, 16'h0000, 2'd1);
      result("t3a", 16'h7FFF, 1'b1);
      beat("t3b_b0", nbig, big, 4'hF, 1'b0, 16'h0000, 2'd0);
      repeat (2) beat("t3b_bm", nbig, big, 4'hF, 1'b0, 16'h0000, 2'd1);
      beat("t3b_b3", nbig, big, 4'hF, 1'b1, 16'h0000, 2'd1);
      result("t3b", 16'h8000, 1'b1);
      beat("t4a", ones, ones, 4'hF, 1'b1, 16'h0100, 2'd0);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("t4_hold_valid", res_valid, 1);
         chk("t4_hold_data", res_data, 16'h0500);
         chk("t4_hold_ready", in_ready, 0);
         @(negedge clk);
      end
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      beat("t4b", '0, '0, 4'hF, 1'b1, 16'h0300, 2'd0);
      result("t4b", 16'h0300, 1'b0);
      garb = ln(16'h0100, 16'h0100, 16'h8100, 16'h8100);
      beat("t5a", garb, ln(16'h0100, 16'h0100, 16'h7F00, 16'h7F00), 4'b0011, 1'b1, 16'h0000, 2'd2);
      result("t5a", 16'h0100, 1'b0);
      beat("t5b", ln(16'h0100, 16'hFF00, 16'h7F00, 16'h7F00), ln(16'h0100, 16'h0100, 16'h7F00, 16'h7F00),
           4'b0011, 1'b1, 16'h0000, 2'd2);
      result("t5b", 16'h0000, 1'b0);
      beat("t6_pre", big, big, 4'hF, 1'b0, 16'h7F00, 2'd0);
      beat("t6_pre2", big, big, 4'hF, 1'b0, 16'h0000, 2'd0);
      rst = 1'b0;
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_in_ready", in_ready, 1);
      chk("t6_res_valid", res_valid, 0);
      chk("t6_res_data", res_data, 0);
      chk("t6_res_sat", res_sat, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      beat("t6", ln(16'h0100, 16'h0200, 16'hFF00, 16'h0080), ln(16'h0100, 16'h0200, 16'hFF00, 16'h0080),
           4'hF, 1'b1, 16'h0000, 2'd0);
      result("t6", 16'h0640, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
